// File: rtl/freq_sweep_scheduler.sv
// freq_sweep_scheduler: SWIPT resonant-frequency search (sweep, average, lock, periodic re-sweep).
// Optional macro LOSS_RESWEEP_EN: TRACK keeps averaging and re-sweeps when amplitude halves.
module freq_sweep_scheduler #(
  parameter logic [19:0] F_START        = 20'h88B8,
  parameter logic [19:0] F_STOP         = 20'hAFC8,
  parameter logic [19:0] F_STEP         = 20'h32,
  parameter logic [23:0] STARTUP_CYCLES = 24'h30D40,
  parameter logic [23:0] SETTLE_CYCLES  = 24'h30D40,
  parameter int unsigned AVG_LOG2       = 2,
  parameter logic [31:0] RESWEEP_CYCLES = 32'd0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swipt_alive,
  input  logic        sweep_go,
  input  logic [11:0] adc,
  input  logic        adc_valid,
  input  logic        freq_ack,
  output logic [19:0] freq_set,
  output logic        freq_req,
  output logic [19:0] best_freq,
  output logic [10:0] best_amp,
  output logic        sweep_done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STARTUP  = 3'd1,
    S_REQ      = 3'd2,
    S_SETTLE   = 3'd3,
    S_MEAS     = 3'd4,
    S_LOCK_REQ = 3'd5,
    S_TRACK    = 3'd6
  } state_t;

  localparam int unsigned SW = 11 + AVG_LOG2;

  state_t              r_state;
  logic [19:0]         r_freq_set;
  logic [19:0]         r_best_freq;
  logic [10:0]         r_best_amp;
  logic                r_freq_req;
  logic                r_sweep_done;
  logic                r_armed;
  logic                r_win;
  logic [31:0]         r_cnt;
  logic [SW-1:0]       r_sum;
  logic [AVG_LOG2-1:0] r_nsmp;

  logic [10:0]         w_mag;
  logic [10:0]         w_avg;
  logic [SW-1:0]       w_sum_next;
  logic [20:0]         w_next;
  logic                w_more;
  logic                w_better;
  logic                w_timer;
  logic                w_loss;

  // Distance from the nearer rail: 0xFFF-adc equals ~adc for the upper half.
  assign w_mag      = adc[11] ? ~adc[10:0] : adc[10:0];
  assign w_sum_next = r_sum + SW'(w_mag);
  assign w_avg      = r_sum[SW-1:AVG_LOG2];
  assign w_next     = {1'b0, r_freq_set} + {1'b0, F_STEP};
  assign w_more     = (w_next <= {1'b0, F_STOP});
  assign w_better   = (w_avg > r_best_amp);
  assign w_timer    = (RESWEEP_CYCLES != 32'd0) && (r_cnt == 32'd0);
`ifdef LOSS_RESWEEP_EN
  assign w_loss     = r_win && (w_avg < (r_best_amp >> 1));
`else
  assign w_loss     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nrst || !swipt_alive) begin
      r_state      <= S_IDLE;
      r_freq_set   <= F_START;
      r_freq_req   <= 1'b0;
      r_best_freq  <= F_START;
      r_best_amp   <= '0;
      r_sweep_done <= 1'b0;
      r_cnt        <= '0;
      r_sum        <= '0;
      r_nsmp       <= '0;
      r_win        <= 1'b0;
      // A link drop needs sweep_go to be seen low before a new search may start.
      r_armed      <= !nrst;
    end else if (r_state != S_IDLE && !sweep_go) begin
      r_state      <= S_IDLE;
      r_freq_req   <= 1'b0;
      r_sweep_done <= 1'b0;
      r_cnt        <= '0;
      r_sum        <= '0;
      r_nsmp       <= '0;
      r_win        <= 1'b0;
      r_armed      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!sweep_go) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= S_STARTUP;
            r_cnt   <= 32'(STARTUP_CYCLES);
          end
        end
        S_STARTUP: begin
          if (r_cnt == 32'd0) begin
            r_state      <= S_REQ;
            r_freq_set   <= F_START;
            r_freq_req   <= 1'b1;
            r_best_amp   <= '0;
            r_sweep_done <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_REQ: begin
          if (freq_ack) begin
            r_state    <= S_SETTLE;
            r_freq_req <= 1'b0;
            r_cnt      <= 32'(SETTLE_CYCLES);
          end
        end
        S_SETTLE: begin
          if (r_cnt == 32'd0) begin
            r_state <= S_MEAS;
            r_sum   <= '0;
            r_nsmp  <= '0;
            r_win   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_MEAS: begin
          if (r_win) begin
            if (w_better) begin
              r_best_amp  <= w_avg;
              r_best_freq <= r_freq_set;
            end
            r_freq_req <= 1'b1;
            if (w_more) begin
              r_state    <= S_REQ;
              r_freq_set <= w_next[19:0];
            end else begin
              r_state    <= S_LOCK_REQ;
              r_freq_set <= w_better ? r_freq_set : r_best_freq;
            end
            r_win  <= 1'b0;
            r_sum  <= '0;
            r_nsmp <= '0;
          end else if (adc_valid) begin
            r_sum  <= w_sum_next;
            r_nsmp <= r_nsmp + 1'b1;
            if (r_nsmp == '1) r_win <= 1'b1;
          end
        end
        S_LOCK_REQ: begin
          if (freq_ack) begin
            r_state      <= S_TRACK;
            r_freq_req   <= 1'b0;
            r_sweep_done <= 1'b1;
            r_cnt        <= RESWEEP_CYCLES;
            r_sum        <= '0;
            r_nsmp       <= '0;
            r_win        <= 1'b0;
          end
        end
        S_TRACK: begin
          if (w_timer || w_loss) begin
            r_state      <= S_REQ;
            r_freq_set   <= F_START;
            r_freq_req   <= 1'b1;
            r_best_amp   <= '0;
            r_sweep_done <= 1'b0;
            r_sum        <= '0;
            r_nsmp       <= '0;
            r_win        <= 1'b0;
          end else begin
            if (r_cnt != 32'd0) r_cnt <= r_cnt - 32'd1;
`ifdef LOSS_RESWEEP_EN
            if (r_win) begin
              r_win  <= 1'b0;
              r_sum  <= '0;
              r_nsmp <= '0;
            end else if (adc_valid) begin
              r_sum  <= w_sum_next;
              r_nsmp <= r_nsmp + 1'b1;
              if (r_nsmp == '1) r_win <= 1'b1;
            end
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign freq_set   = r_freq_set;
  assign freq_req   = r_freq_req;
  assign best_freq  = r_best_freq;
  assign best_amp   = r_best_amp;
  assign sweep_done = r_sweep_done;
  assign state      = r_state;

endmodule

// File: tb/tb_freq_sweep_scheduler.sv
// Bench for freq_sweep_scheduler: two instances (no re-sweep / 10-cycle re-sweep) driven by
// a generator/ADC responder, checked against a per-point averaging model.
module tb_freq_sweep_scheduler;

  localparam logic [19:0] FSTART = 20'h88B8;
  localparam logic [19:0] FSTOP  = 20'h8980;
  localparam logic [19:0] FSTEP  = 20'h32;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        alive = 1'b1;
  logic        go0 = 1'b0;
  logic        go1 = 1'b0;
  logic [11:0] adc = '0;
  logic        adc_valid = 1'b0;
  logic        ack = 1'b0;

  logic [19:0] set0, set1, bf0, bf1;
  logic [10:0] ba0, ba1;
  logic        req0, req1, done0, done1;
  logic [2:0]  st0, st1;

  logic [19:0] o_set, o_bf;
  logic [10:0] o_ba;
  logic        o_req, o_done;
  logic [2:0]  o_state;

  bit sel = 1'b0;
  int nvec = 0;
  int nmis = 0;
  int m_bf[2];
  int m_ba[2];

  always #5 clk = ~clk;

  freq_sweep_scheduler #(
    .F_START(FSTART), .F_STOP(FSTOP), .F_STEP(FSTEP),
    .STARTUP_CYCLES(24'd4), .SETTLE_CYCLES(24'd4), .AVG_LOG2(2), .RESWEEP_CYCLES(32'd0)
  ) dut (
    .clk(clk), .nrst(nrst), .swipt_alive(alive), .sweep_go(go0), .adc(adc),
    .adc_valid(adc_valid), .freq_ack(ack), .freq_set(set0), .freq_req(req0),
    .best_freq(bf0), .best_amp(ba0), .sweep_done(done0), .state(st0)
  );

  freq_sweep_scheduler #(
    .F_START(FSTART), .F_STOP(FSTOP), .F_STEP(FSTEP),
    .STARTUP_CYCLES(24'd4), .SETTLE_CYCLES(24'd4), .AVG_LOG2(2), .RESWEEP_CYCLES(32'd10)
  ) dut_rs (
    .clk(clk), .nrst(nrst), .swipt_alive(alive), .sweep_go(go1), .adc(adc),
    .adc_valid(adc_valid), .freq_ack(ack), .freq_set(set1), .freq_req(req1),
    .best_freq(bf1), .best_amp(ba1), .sweep_done(done1), .state(st1)
  );

  always_comb begin
    o_set   = sel ? set1  : set0;
    o_bf    = sel ? bf1   : bf0;
    o_ba    = sel ? ba1   : ba0;
    o_req   = sel ? req1  : req0;
    o_done  = sel ? done1 : done0;
    o_state = sel ? st1   : st0;
  end

  function automatic int mag_of(input int a);
    return (a < 2048) ? a : 4095 - a;
  endfunction

  function automatic int gen_adc(input int mode, input int f, input int i);
    case (mode)
      1:       return (i % 2 == 0) ? 'h7FF : 'h800;
      2:       return (f == 'h891C) ? 'h7F0 : 'h100;
      3:       return 'h100;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic set_go(input bit v);
    if (sel) go1 = v; else go0 = v;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_req === 1'b1) begin ok = 1'b1; return; end
      @(negedge clk);
    end
    nvec++; nmis++;
    $display("FAIL req_timeout got no freq_req within 40 cycles exp freq_req=1");
  endtask

  task automatic wait_state(input logic [2:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_state === s) begin ok = 1'b1; return; end
      @(negedge clk);
    end
    nvec++; nmis++;
    $display("FAIL state_timeout got %0d exp %0d within 40 cycles", o_state, s);
  endtask

  task automatic ack_it();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    nvec++;
    if (o_req !== 1'b0) begin nmis++; $display("FAIL req_drop got %b exp 0", o_req); end
  endtask

  // One full search on the selected instance; abort_pt >= 0 withdraws sweep_go in that point's SETTLE.
  task automatic sweep(input int mode, input int abort_pt);
    int f;
    int sum;
    int a;
    int k;
    bit ok;
    k = sel ? 1 : 0;
    f = FSTART;
    m_ba[k] = 0;
    for (int p = 0; p < 16; p++) begin
      wait_req(ok);
      if (!ok) return;
      nvec++;
      if (o_set !== 20'(f)) begin nmis++; $display("FAIL req_freq pt%0d got %h exp %h", p, o_set, 20'(f)); end
      ack_it();
      nvec++;
      if (o_state !== 3'd3) begin nmis++; $display("FAIL settle_entry got %0d exp 3", o_state); end
      if (p == abort_pt) begin
        @(negedge clk);
        set_go(1'b0);
        @(negedge clk);
        nvec++;
        if (o_state !== 3'd0) begin nmis++; $display("FAIL abort_state got %0d exp 0", o_state); end
        nvec++;
        if (o_req !== 1'b0) begin nmis++; $display("FAIL abort_req got %b exp 0", o_req); end
        nvec++;
        if (o_bf !== 20'(m_bf[k])) begin nmis++; $display("FAIL abort_best_freq got %h exp %h", o_bf, 20'(m_bf[k])); end
        nvec++;
        if (o_ba !== 11'(m_ba[k])) begin nmis++; $display("FAIL abort_best_amp got %h exp %h", o_ba, 11'(m_ba[k])); end
        nvec++;
        if (o_done !== 1'b0) begin nmis++; $display("FAIL abort_done got %b exp 0", o_done); end
        set_go(1'b1);
        @(negedge clk);
        nvec++;
        if (o_state !== 3'd1) begin nmis++; $display("FAIL restart_state got %0d exp 1", o_state); end
        return;
      end
      wait_state(3'd4, ok);
      if (!ok) return;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) begin
          adc = 12'($urandom);
          adc_valid = 1'b0;
          @(negedge clk);
        end
        a = gen_adc(mode, f, i);
        adc = 12'(a);
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        sum += mag_of(a);
      end
      if (sum / 4 > m_ba[k]) begin m_ba[k] = sum / 4; m_bf[k] = f; end
      if (f + int'(FSTEP) > int'(FSTOP)) break;
      f = f + int'(FSTEP);
    end
    wait_req(ok);
    if (!ok) return;
    nvec++;
    if (o_set !== 20'(m_bf[k])) begin nmis++; $display("FAIL lock_freq got %h exp %h", o_set, 20'(m_bf[k])); end
    ack_it();
    nvec++;
    if (o_state !== 3'd6) begin nmis++; $display("FAIL track_state got %0d exp 6", o_state); end
    nvec++;
    if (o_done !== 1'b1) begin nmis++; $display("FAIL sweep_done got %b exp 1", o_done); end
    nvec++;
    if (o_bf !== 20'(m_bf[k])) begin nmis++; $display("FAIL best_freq got %h exp %h", o_bf, 20'(m_bf[k])); end
    nvec++;
    if (o_ba !== 11'(m_ba[k])) begin nmis++; $display("FAIL best_amp got %h exp %h", o_ba, 11'(m_ba[k])); end
  endtask

  task automatic restart();
    set_go(1'b0);
    @(negedge clk);
    set_go(1'b1);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      nvec++;
      if (o_state !== 3'd0) begin nmis++; $display("FAIL reset_state%0d got %0d exp 0", s, o_state); end
      nvec++;
      if (o_req !== 1'b0) begin nmis++; $display("FAIL reset_req%0d got %b exp 0", s, o_req); end
      nvec++;
      if (o_set !== FSTART || o_bf !== FSTART) begin
        nmis++; $display("FAIL reset_freq%0d got %h/%h exp %h", s, o_set, o_bf, FSTART);
      end
      nvec++;
      if (o_ba !== 11'd0 || o_done !== 1'b0) begin
        nmis++; $display("FAIL reset_amp_done%0d got %h/%b exp 0/0", s, o_ba, o_done);
      end
      m_bf[s] = FSTART;
      m_ba[s] = 0;
    end
    sel = 1'b0;
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    sel = 1'b0;
    go0 = 1'b1;
    sweep(2, -1);
    nvec++;
    if (o_bf !== 20'h891C || o_ba !== 11'h7F0) begin
      nmis++; $display("FAIL peak_lock got %h/%h exp 891c/7f0", o_bf, o_ba);
    end
    repeat (30) @(negedge clk);
    nvec++;
    if (o_state !== 3'd6 || o_req !== 1'b0) begin
      nmis++; $display("FAIL track_hold got state %0d req %b exp 6/0", o_state, o_req);
    end
  endtask

  task automatic test_tie();
    restart();
    sweep(1, -1);
    nvec++;
    if (o_bf !== FSTART || o_ba !== 11'h7FF) begin
      nmis++; $display("FAIL tie_7ff got %h/%h exp %h/7ff", o_bf, o_ba, FSTART);
    end
    restart();
    sweep(3, -1);
    nvec++;
    if (o_bf !== FSTART || o_ba !== 11'h100) begin
      nmis++; $display("FAIL tie_100 got %h/%h exp %h/100", o_bf, o_ba, FSTART);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      restart();
      sweep(0, -1);
    end
  endtask

  task automatic test_abort();
    restart();
    sweep(0, 2);
    sweep(0, -1);
  endtask

  task automatic test_resweep();
    int n;
    go0 = 1'b0;
    sel = 1'b1;
    @(negedge clk);
    go1 = 1'b1;
    sweep(0, -1);
    n = 0;
    while (o_state === 3'd6 && n < 40) begin n++; @(negedge clk); end
    nvec++;
    if (n < 10 || n > 11) begin nmis++; $display("FAIL resweep_time got %0d cycles exp 10..11", n); end
    nvec++;
    if (o_req !== 1'b1 || o_set !== FSTART) begin
      nmis++; $display("FAIL resweep_req got %b/%h exp 1/%h", o_req, o_set, FSTART);
    end
    nvec++;
    if (o_done !== 1'b0 || o_ba !== 11'd0) begin
      nmis++; $display("FAIL resweep_clear got %b/%h exp 0/0", o_done, o_ba);
    end
    sweep(0, -1);
    go1 = 1'b0;
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loss();
    bit ok;
    sel = 1'b0;
    go0 = 1'b1;
    sweep(2, -1);
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      adc = 12'h010;
      adc_valid = 1'b1;
      @(negedge clk);
    end
    adc_valid = 1'b0;
`ifdef LOSS_RESWEEP_EN
    wait_req(ok);
    if (ok) begin
      nvec++;
      if (o_set !== FSTART || o_done !== 1'b0) begin
        nmis++; $display("FAIL loss_resweep got %h/%b exp %h/0", o_set, o_done, FSTART);
      end
      sweep(0, -1);
    end
`else
    ok = 1'b1;
    repeat (10) @(negedge clk);
    nvec++;
    if (o_state !== 3'd6 || o_req !== 1'b0 || o_done !== 1'b1) begin
      nmis++; $display("FAIL loss_ignored got state %0d req %b done %b exp 6/0/1", o_state, o_req, o_done);
    end
    nvec++;
    if (o_ba !== 11'(m_ba[0])) begin nmis++; $display("FAIL loss_amp got %h exp %h", o_ba, 11'(m_ba[0])); end
`endif
  endtask

  task automatic test_alive();
    sel = 1'b0;
    alive = 1'b0;
    @(negedge clk);
    nvec++;
    if (o_state !== 3'd0 || o_req !== 1'b0 || o_done !== 1'b0) begin
      nmis++; $display("FAIL alive_drop got state %0d req %b done %b exp 0/0/0", o_state, o_req, o_done);
    end
    nvec++;
    if (o_bf !== FSTART || o_ba !== 11'd0 || o_set !== FSTART) begin
      nmis++; $display("FAIL alive_clear got %h/%h/%h exp %h/0/%h", o_bf, o_ba, o_set, FSTART, FSTART);
    end
    alive = 1'b1;
    repeat (8) @(negedge clk);
    nvec++;
    if (o_state !== 3'd0) begin nmis++; $display("FAIL alive_not_rearmed got %0d exp 0", o_state); end
    go0 = 1'b0;
    @(negedge clk);
    go0 = 1'b1;
    @(negedge clk);
    nvec++;
    if (o_state !== 3'd1) begin nmis++; $display("FAIL alive_rearm got %0d exp 1", o_state); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sweep();
    test_tie();
    test_random();
    test_abort();
    test_resweep();
    test_loss();
    test_alive();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete exp finish before 2ms");
    $fatal(1);
  end

endmodule
